issue_ctrl: RTL and testbench
=============================

# issue_ctrl

In-order issue controller between decode and execute. Each cycle it decides whether the decoded instruction may issue. It stalls decode on RAW or WAW hazards against in-flight register writes, on write-port conflicts between the fixed-latency ALU and MUL paths, and on a second outstanding load. It also drives write-enable and destination-register control for the shared ALU/MUL register-file write port.

## Interface
Parameters:
- ALU_WB_LAT, 2, cycles from issue to ALU/AUIPC writeback (≥1)
- MUL_WB_LAT, 6, cycles from issue to MUL writeback (> ALU_WB_LAT)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- dec_valid  in  1  decoded instruction present
- dec_instr_type  in  `INSTR_TYPE_SZ  decoder class (`INSTR_TYPE_ALU/MUL/LOAD/STORE/NO_WB)
- dec_rs1, dec_rs2, dec_rd  in  `ARCH_REG_INDEX_SIZE each  register indices
- dec_uses_rs1, dec_uses_rs2  in  1 each  operand actually read
- ex_ready  in  1  execute stage can accept an instruction
- flush  in  1  kill the decode-stage instruction this cycle
- mem_wb_valid  in  1  load data written this cycle (load write port)
- mem_wb_rd  in  `ARCH_REG_INDEX_SIZE  load destination
- issue  out  1  instruction issues this cycle
- dec_stall  out  1  dec_valid & !issue & !flush
- wb_valid  out  1  ALU/MUL write port writes this cycle
- wb_rd  out  `ARCH_REG_INDEX_SIZE  destination for wb_valid
- wb_is_mul  out  1  write-port source select: 1 = MUL, 0 = ALU

## Operation
- State: busy[31:0] bits, with busy[0] forced to 0. Writeback reservation shift register sr[0..MUL_WB_LAT-1], each entry holding {valid, rd, is_mul}. Flag load_pending.
- writes_rd = type ∈ {ALU, MUL, LOAD} and dec_rd ≠ 0. Types STORE and NO_WB never set busy.
- raw = (dec_uses_rs1 & busy[dec_rs1]) | (dec_uses_rs2 & busy[dec_rs2]). Reads of x0 never hazard.
- waw = writes_rd & busy[dec_rd].
- Structural hazards:
  - ALU requires sr[ALU_WB_LAT].valid = 0.
  - MUL requires sr[MUL_WB_LAT].valid = 0; treat an index equal to the depth as empty.
  - LOAD requires load_pending = 0.
- issue = dec_valid & ex_ready & !flush & !raw & !waw & !struct.
- Hazard checks use registered state only. There is no same-cycle bypass of a clear.
- Shift register, every cycle: sr[k] ← sr[k+1], and the top entry ← empty.
- On an ALU/MUL issue, sr[L-1] ← {1, dec_rd, is_mul}, with L = ALU_WB_LAT or MUL_WB_LAT. This write overrides the shift into that slot; the slot is guaranteed empty by the structural check.
- An ALU/MUL issue with dec_rd = 0 still reserves its slot, with rd = 0.
- wb_valid, wb_rd and wb_is_mul are sr[0] fields, combinational from the register.
- busy updates at the clock edge:
  - Clear busy[sr[0].rd] if sr[0].valid.
  - Clear busy[mem_wb_rd] if mem_wb_valid, and clear load_pending.
  - Then set busy[dec_rd] if issue & writes_rd. Set load_pending on a LOAD issue.
  - Set has priority over clear for the same index. This is unreachable in legal operation because of the WAW check.
- mem_wb_valid with load_pending = 0 is ignored for load_pending, but still clears busy.
- flush suppresses issue only. In-flight reservations and busy bits drain normally.

## Timing
- Reset (reset = 0 at a clock edge): busy = 0, all sr entries invalid, load_pending = 0.
  - Outputs after reset: wb_valid = 0, wb_rd = 0, wb_is_mul = 0.
  - issue and dec_stall are 0 while reset is asserted.
- Reset mid-operation discards all reservations. No writeback occurs for instructions issued before reset.
- An ALU issued in cycle t produces wb_valid in cycle t+ALU_WB_LAT. A MUL issued in cycle t produces wb_valid in cycle t+MUL_WB_LAT.
- busy clears at the end of the writeback cycle. A dependent instruction can issue no earlier than writeback cycle + 1.
  - ALU→ALU dependent gap = ALU_WB_LAT+1 cycles.
- issue and dec_stall are combinational from current inputs and state, with zero latency.
- One issue per cycle maximum. The ALU/MUL port and the load port can both write in the same cycle.

## Test plan
- Reset, then an independent ALU stream with x1..x5 destinations and ex_ready = 1 → issue every cycle; wb_valid with rd = 1 at cycle 2, then rd = 2..5 on consecutive cycles.
- MUL x3 at cycle 0, then ALU with rs1 = x3 → stall cycles 1–6, issue at cycle 7; wb_valid rd = 3 with wb_is_mul = 1 at cycle 6.
- MUL at cycle 0, then an independent ALU at cycle 4 (default latencies) → slot 2 is taken, so the ALU stalls one cycle and issues at cycle 5; there is never a double write.
- LOAD x7, then LOAD x8 → the second load stalls until the cycle after mem_wb_valid with mem_wb_rd = 7, then issues.
- ALU with rd = x0, then a reader of x0 → no busy bit is set and there is no stall; wb_valid rd = 0 still occurs.
- MUL outstanding, reset pulsed at cycle 3 → wb_valid stays 0 through cycle 10; the next dependent instruction issues without stalling.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback signal bundle for the in-order issue controller.
// The decoder side uses the master modport; issue_ctrl uses the slave modport.
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`define INSTR_TYPE_ALU   3'd0
`define INSTR_TYPE_MUL   3'd1
`define INSTR_TYPE_LOAD  3'd2
`define INSTR_TYPE_STORE 3'd3
`define INSTR_TYPE_NO_WB 3'd4
`endif

interface issue_ctrl_if;
    logic                            dec_valid;
    logic [`INSTR_TYPE_SZ-1:0]       dec_instr_type;
    logic [`ARCH_REG_INDEX_SIZE-1:0] dec_rs1;
    logic [`ARCH_REG_INDEX_SIZE-1:0] dec_rs2;
    logic [`ARCH_REG_INDEX_SIZE-1:0] dec_rd;
    logic                            dec_uses_rs1;
    logic                            dec_uses_rs2;
    logic                            ex_ready;
    logic                            flush;
    logic                            mem_wb_valid;
    logic [`ARCH_REG_INDEX_SIZE-1:0] mem_wb_rd;
    logic                            issue;
    logic                            dec_stall;
    logic                            wb_valid;
    logic [`ARCH_REG_INDEX_SIZE-1:0] wb_rd;
    logic                            wb_is_mul;

    modport master (
        output dec_valid, dec_instr_type, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, ex_ready, flush,
               mem_wb_valid, mem_wb_rd,
        input  issue, dec_stall, wb_valid, wb_rd, wb_is_mul
    );

    modport slave (
        input  dec_valid, dec_instr_type, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, ex_ready, flush,
               mem_wb_valid, mem_wb_rd,
        output issue, dec_stall, wb_valid, wb_rd, wb_is_mul
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: RAW/WAW scoreboard, shared ALU/MUL write-port
// reservation shift register, and single outstanding load tracking.
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`define INSTR_TYPE_ALU   3'd0
`define INSTR_TYPE_MUL   3'd1
`define INSTR_TYPE_LOAD  3'd2
`define INSTR_TYPE_STORE 3'd3
`define INSTR_TYPE_NO_WB 3'd4
`endif

module issue_ctrl #(
    parameter int ALU_WB_LAT = 2,
    parameter int MUL_WB_LAT = 6
) (
    input logic         clk,
    input logic         reset,
    issue_ctrl_if.slave bus
);

    localparam int RW    = `ARCH_REG_INDEX_SIZE;
    localparam int NREGS = 1 << RW;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          isMul;
    } srEntry_t;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             loadPending_q, loadPending_d;
    srEntry_t         sr_q [MUL_WB_LAT];
    srEntry_t         sr_d [MUL_WB_LAT];

    logic isAlu, isMul, isLoad, writesRd;
    logic raw, waw, structHazard, aluSlotFree, issueOk;

    assign isAlu    = (bus.dec_instr_type == `INSTR_TYPE_ALU);
    assign isMul    = (bus.dec_instr_type == `INSTR_TYPE_MUL);
    assign isLoad   = (bus.dec_instr_type == `INSTR_TYPE_LOAD);
    assign writesRd = (isAlu | isMul | isLoad) & (bus.dec_rd != '0);

    // busy[0] is held at 0 by the update logic, so x0 reads never hazard.
    assign raw = (bus.dec_uses_rs1 & busy_q[bus.dec_rs1]) |
                 (bus.dec_uses_rs2 & busy_q[bus.dec_rs2]);
    assign waw = writesRd & busy_q[bus.dec_rd];

    // A MUL lands in the top slot, whose shift source lies past the end and is always empty.
    assign aluSlotFree  = ~sr_q[ALU_WB_LAT].valid;
    assign structHazard = (isAlu & ~aluSlotFree) | (isLoad & loadPending_q);

    assign issueOk = reset & bus.dec_valid & bus.ex_ready & ~bus.flush &
                     ~raw & ~waw & ~structHazard;

    assign bus.issue     = issueOk;
    assign bus.dec_stall = reset & bus.dec_valid & ~issueOk & ~bus.flush;
    assign bus.wb_valid  = sr_q[0].valid;
    assign bus.wb_rd     = sr_q[0].rd;
    assign bus.wb_is_mul = sr_q[0].isMul;

    always_comb begin
        for (int k = 0; k < MUL_WB_LAT - 1; k++) begin
            sr_d[k] = sr_q[k + 1];
        end
        sr_d[MUL_WB_LAT-1] = '0;
        if (issueOk && isAlu) begin
            sr_d[ALU_WB_LAT-1] = {1'b1, bus.dec_rd, 1'b0};
        end
        if (issueOk && isMul) begin
            sr_d[MUL_WB_LAT-1] = {1'b1, bus.dec_rd, 1'b1};
        end
    end

    // Clears first, then sets, so a set wins on the same index.
    always_comb begin
        busy_d        = busy_q;
        loadPending_d = loadPending_q;
        if (sr_q[0].valid) begin
            busy_d[sr_q[0].rd] = 1'b0;
        end
        if (bus.mem_wb_valid) begin
            busy_d[bus.mem_wb_rd] = 1'b0;
            loadPending_d         = 1'b0;
        end
        if (issueOk && writesRd) begin
            busy_d[bus.dec_rd] = 1'b1;
        end
        if (issueOk && isLoad) begin
            loadPending_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q        <= '0;
            loadPending_q <= 1'b0;
            for (int k = 0; k < MUL_WB_LAT; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            loadPending_q <= loadPending_d;
            sr_q          <= sr_d;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with default latencies (ALU 2, MUL 6).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`define INSTR_TYPE_ALU   3'd0
`define INSTR_TYPE_MUL   3'd1
`define INSTR_TYPE_LOAD  3'd2
`define INSTR_TYPE_STORE 3'd3
`define INSTR_TYPE_NO_WB 3'd4
`endif

module tb_issue_ctrl;

    localparam logic [2:0] T_ALU  = `INSTR_TYPE_ALU;
    localparam logic [2:0] T_MUL  = `INSTR_TYPE_MUL;
    localparam logic [2:0] T_LOAD = `INSTR_TYPE_LOAD;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    issue_ctrl_if bus();

    issue_ctrl #(
        .ALU_WB_LAT(2),
        .MUL_WB_LAT(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] t,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd);
        bus.dec_valid      = v;
        bus.dec_instr_type = t;
        bus.dec_rs1        = rs1;
        bus.dec_uses_rs1   = u1;
        bus.dec_rs2        = rs2;
        bus.dec_uses_rs2   = u2;
        bus.dec_rd         = rd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit eIssue, input bit eStall,
                               input bit eWbv, input int eRd, input bit eMul);
        check({tag, "_issue"}, 32'(bus.issue), 32'(eIssue));
        check({tag, "_stall"}, 32'(bus.dec_stall), 32'(eStall));
        check({tag, "_wbv"}, 32'(bus.wb_valid), 32'(eWbv));
        if (eWbv) begin
            check({tag, "_wbrd"}, 32'(bus.wb_rd), 32'(eRd));
            check({tag, "_wbmul"}, 32'(bus.wb_is_mul), 32'(eMul));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with a valid instruction presented: nothing may issue or stall.
        reset            = 1'b0;
        bus.flush        = 1'b0;
        bus.ex_ready     = 1'b1;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wb_rd    = 5'd0;
        applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
        #1;
        check("rst_pre_issue", 32'(bus.issue), 32'd0);
        check("rst_pre_stall", 32'(bus.dec_stall), 32'd0);
        nextCycle();
        checkOutput("rst_regs", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("rst_wbrd", 32'(bus.wb_rd), 32'd0);
        check("rst_wbmul", 32'(bus.wb_is_mul), 32'd0);
        nextCycle();
        reset = 1'b1;
        idle();
        nextCycle();

        $display("[TB] independent ALU stream");
        for (int c = 0; c < 8; c++) begin
            if (c < 5) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'(c + 1));
            else idle();
            #1;
            checkOutput($sformatf("alu_stream_c%0d", c), c < 5, 1'b0,
                        (c >= 2) && (c <= 6), c - 1, 1'b0);
            nextCycle();
        end

        $display("[TB] MUL x3 then dependent ALU");
        for (int c = 0; c < 10; c++) begin
            if (c == 0) applyStimulus(1'b1, T_MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
            else if (c <= 7) applyStimulus(1'b1, T_ALU, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9);
            else idle();
            #1;
            checkOutput($sformatf("mul_raw_c%0d", c), (c == 0) || (c == 7),
                        (c >= 1) && (c <= 6), (c == 6) || (c == 9),
                        (c == 6) ? 3 : 9, c == 6);
            nextCycle();
        end

        $display("[TB] write-port conflict MUL vs ALU");
        for (int c = 0; c < 8; c++) begin
            if (c == 0) applyStimulus(1'b1, T_MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10);
            else if (c == 4 || c == 5) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11);
            else idle();
            #1;
            checkOutput($sformatf("port_c%0d", c), (c == 0) || (c == 5), c == 4,
                        (c == 6) || (c == 7), (c == 6) ? 10 : 11, c == 6);
            nextCycle();
        end

        $display("[TB] back-to-back loads and load-use");
        for (int c = 0; c < 9; c++) begin
            if (c == 0) applyStimulus(1'b1, T_LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7);
            else if (c <= 3) applyStimulus(1'b1, T_LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
            else if (c <= 6) applyStimulus(1'b1, T_ALU, 5'd8, 1'b1, 5'd0, 1'b0, 5'd15);
            else idle();
            bus.mem_wb_valid = (c == 2) || (c == 5);
            bus.mem_wb_rd    = (c == 2) ? 5'd7 : 5'd8;
            #1;
            checkOutput($sformatf("load_c%0d", c), (c == 0) || (c == 3) || (c == 6),
                        (c == 1) || (c == 2) || (c == 4) || (c == 5),
                        c == 8, 15, 1'b0);
            nextCycle();
        end
        bus.mem_wb_valid = 1'b0;

        $display("[TB] x0 destination and x0 readers");
        for (int c = 0; c < 4; c++) begin
            if (c == 0) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            else if (c == 1) applyStimulus(1'b1, T_ALU, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12);
            else idle();
            #1;
            checkOutput($sformatf("x0_c%0d", c), c <= 1, 1'b0, c >= 2,
                        (c == 2) ? 0 : 12, 1'b0);
            nextCycle();
        end

        $display("[TB] flush, WAW and ex_ready backpressure");
        for (int c = 0; c < 8; c++) begin
            if (c <= 3) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13);
            else if (c <= 5) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14);
            else idle();
            bus.flush    = (c == 1);
            bus.ex_ready = (c != 4);
            #1;
            checkOutput($sformatf("waw_c%0d", c), (c == 0) || (c == 3) || (c == 5),
                        (c == 2) || (c == 4), (c == 2) || (c == 5) || (c == 7),
                        (c == 7) ? 14 : 13, 1'b0);
            nextCycle();
        end
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;

        $display("[TB] reset discards an in-flight MUL");
        for (int c = 0; c < 14; c++) begin
            if (c == 0) applyStimulus(1'b1, T_MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20);
            else if (c == 3) applyStimulus(1'b1, T_ALU, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22);
            else if (c == 11) applyStimulus(1'b1, T_ALU, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21);
            else idle();
            reset = (c != 3);
            #1;
            checkOutput($sformatf("midrst_c%0d", c), (c == 0) || (c == 11), 1'b0,
                        c == 13, 21, 1'b0);
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
